// File: rtl/micro_sequencer.sv
// Microcoded control sequencer for an 8-bit accumulator CPU: fetch/decode/execute
// FSM whose strobes are a function of state and mem_ready only.
module micro_sequencer #(
  parameter int OPW          = 8,
  parameter int MEM_WAIT_EN  = 1,
  parameter int ILLEGAL_HALT = 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [OPW-1:0] IR,
  input  logic [3:0]     CCR,
  input  logic           mem_ready,
  output logic           IR_Load,
  output logic           MAR_Load,
  output logic           PC_Load,
  output logic           PC_Inc,
  output logic           A_Load,
  output logic           B_Load,
  output logic           CCR_Load,
  output logic           write,
  output logic [2:0]     ALU_Sel,
  output logic [1:0]     Bus1_Sel,
  output logic [1:0]     Bus2_Sel,
  output logic           halted,
  output logic           illegal
);

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                         ALU_OR  = 3'b011, ALU_INC = 3'b100, ALU_DEC = 3'b101;
  localparam logic [1:0] B1_PC = 2'b00, B1_A = 2'b01, B1_B = 2'b10;
  localparam logic [1:0] B2_ALU = 2'b00, B2_BUS1 = 2'b01, B2_MEM = 2'b10;

  // Each flow owns its post-prefix states so outputs never need to look at IR.
  typedef enum logic [4:0] {
    S_FETCH_0 = 5'd0, S_FETCH_1, S_FETCH_2, S_DECODE, S_OP_0, S_OP_1,
    S_LDA_IMM, S_LDB_IMM, S_DIR_ADDR, S_LDA_DIR, S_LDB_DIR, S_STA_DIR, S_STB_DIR,
    S_BR_LOAD, S_EX_ADD, S_EX_SUB, S_EX_AND, S_EX_OR, S_EX_INC, S_EX_DEC,
    S_SKIP, S_HALT
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  logic             mr;
  logic [OPW+7:0]   ir_ext;
  logic [7:0]       op8;
  logic             hi_zero;
  logic             is_branch;
  logic             br_taken;

  assign mr      = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
  assign ir_ext  = {8'h00, IR};
  assign op8     = ir_ext[7:0];
  assign hi_zero = (ir_ext[OPW+7:8] == '0);
  assign is_branch = hi_zero && (op8 >= 8'h20) && (op8 <= 8'h28);

  always_comb begin
    br_taken = 1'b0;
    case (op8)
      8'h20: br_taken = 1'b1;
      8'h21: br_taken = CCR[3];
      8'h22: br_taken = ~CCR[3];
      8'h23: br_taken = CCR[2];
      8'h24: br_taken = ~CCR[2];
      8'h25: br_taken = CCR[1];
      8'h26: br_taken = ~CCR[1];
      8'h27: br_taken = CCR[0];
      8'h28: br_taken = ~CCR[0];
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH_0: state_d = S_FETCH_1;
      S_FETCH_1: state_d = S_FETCH_2;
      S_FETCH_2: if (mr) state_d = S_DECODE;
      S_DECODE: begin
        if (!hi_zero) begin
          if (ILLEGAL_HALT != 0) begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end else begin
            state_d = S_FETCH_0;
          end
        end else if (is_branch) begin
          state_d = br_taken ? S_OP_0 : S_SKIP;
        end else begin
          case (op8)
            8'h00: state_d = S_FETCH_0;
            8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97: state_d = S_OP_0;
            8'h42: state_d = S_EX_ADD;
            8'h43: state_d = S_EX_SUB;
            8'h44: state_d = S_EX_AND;
            8'h45: state_d = S_EX_OR;
            8'h46: state_d = S_EX_INC;
            8'h47: state_d = S_EX_DEC;
            8'hFF: state_d = S_HALT;
            default: begin
              if (ILLEGAL_HALT != 0) begin
                state_d   = S_HALT;
                illegal_d = 1'b1;
              end else begin
                state_d = S_FETCH_0;
              end
            end
          endcase
        end
      end
      S_OP_0: state_d = S_OP_1;
      S_OP_1: begin
        state_d = S_FETCH_0;
        if (is_branch) state_d = S_BR_LOAD;
        else if (hi_zero) begin
          case (op8)
            8'h86: state_d = S_LDA_IMM;
            8'h88: state_d = S_LDB_IMM;
            8'h87, 8'h89, 8'h96, 8'h97: state_d = S_DIR_ADDR;
            default: state_d = S_FETCH_0;
          endcase
        end
      end
      S_DIR_ADDR: begin
        if (mr) begin
          state_d = S_FETCH_0;
          if (hi_zero) begin
            case (op8)
              8'h87: state_d = S_LDA_DIR;
              8'h89: state_d = S_LDB_DIR;
              8'h96: state_d = S_STA_DIR;
              8'h97: state_d = S_STB_DIR;
              default: state_d = S_FETCH_0;
            endcase
          end
        end
      end
      S_LDA_IMM, S_LDB_IMM, S_LDA_DIR, S_LDB_DIR,
      S_STA_DIR, S_STB_DIR, S_BR_LOAD: if (mr) state_d = S_FETCH_0;
      S_EX_ADD, S_EX_SUB, S_EX_AND, S_EX_OR,
      S_EX_INC, S_EX_DEC, S_SKIP: state_d = S_FETCH_0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH_0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH_0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Loads in memory states only fire on the completing cycle; write holds.
  always_comb begin
    IR_Load  = 1'b0;
    MAR_Load = 1'b0;
    PC_Load  = 1'b0;
    PC_Inc   = 1'b0;
    A_Load   = 1'b0;
    B_Load   = 1'b0;
    CCR_Load = 1'b0;
    write    = 1'b0;
    ALU_Sel  = ALU_ADD;
    Bus1_Sel = B1_PC;
    Bus2_Sel = B2_ALU;
    halted   = 1'b0;
    illegal  = illegal_q;
    case (state_q)
      S_FETCH_0, S_OP_0: begin
        Bus1_Sel = B1_PC;
        Bus2_Sel = B2_BUS1;
        MAR_Load = 1'b1;
      end
      S_FETCH_1, S_OP_1, S_SKIP: PC_Inc = 1'b1;
      S_FETCH_2:  begin Bus2_Sel = B2_MEM; IR_Load  = mr; end
      S_LDA_IMM, S_LDA_DIR: begin Bus2_Sel = B2_MEM; A_Load = mr; end
      S_LDB_IMM, S_LDB_DIR: begin Bus2_Sel = B2_MEM; B_Load = mr; end
      S_DIR_ADDR: begin Bus2_Sel = B2_MEM; MAR_Load = mr; end
      S_STA_DIR:  begin Bus1_Sel = B1_A; write = 1'b1; end
      S_STB_DIR:  begin Bus1_Sel = B1_B; write = 1'b1; end
      S_BR_LOAD:  begin Bus2_Sel = B2_MEM; PC_Load = mr; end
      S_EX_ADD, S_EX_SUB, S_EX_AND, S_EX_OR, S_EX_INC, S_EX_DEC: begin
        Bus1_Sel = B1_B;
        Bus2_Sel = B2_ALU;
        A_Load   = 1'b1;
        CCR_Load = 1'b1;
        case (state_q)
          S_EX_SUB: ALU_Sel = ALU_SUB;
          S_EX_AND: ALU_Sel = ALU_AND;
          S_EX_OR:  ALU_Sel = ALU_OR;
          S_EX_INC: begin ALU_Sel = ALU_INC; Bus1_Sel = B1_A; end
          S_EX_DEC: begin ALU_Sel = ALU_DEC; Bus1_Sel = B1_A; end
          default:  ALU_Sel = ALU_ADD;
        endcase
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule
